mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit (HI/LO holder) for the MIPS datapath.
- Sits directly downstream of the ALU B-operand select. It consumes rs data as A and the selected B operand, in parallel with the ALU.
- Holds the architectural HI and LO registers. Exposes busy so the control/stall logic can freeze dependent MFHI/MFLO and new MDU instructions.

Parameters:
- MULT_LAT, 5, cycles busy is held for MULT/MULTU (legal range 1..31)
- DIV_LAT, 10, cycles busy is held for DIV/DIVU (legal range 1..31)

Ports:
- clk  input  1  system clock, all state updates on posedge
- reset  input  1  synchronous, active-high reset
- md_op  input  3  operation request: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- A  input  32  operand A (rs value)
- B  input  32  operand B (selected second operand)
- busy  output  1  high while a mult/div is in flight
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (synchronous, active-high): at posedge with reset=1, hi=0, lo=0, busy=0, counter=0, pending result discarded.
  - Reset has priority over every md_op, including mid-operation. No result is written afterwards.
- Acceptance: md_op is sampled only at a posedge with busy=0. Any md_op while busy=1 is ignored; control must stall.
- MTHI/MTLO, idle: at the accepting edge, hi<=A (MTHI) or lo<=A (MTLO), with visible 1-cycle latency. The other register is unchanged and busy stays 0.
- MULT/MULTU/DIV/DIVU, idle: at the accepting edge:
  - latch A, B and op
  - load counter with MULT_LAT or DIV_LAT
  - busy<=1
- In flight:
  - counter decrements at each posedge.
  - At the edge where counter goes 1->0, hi/lo are written with the result and busy<=0 at the same edge.
  - busy is therefore high for exactly LAT cycles. hi/lo hold their old values until the completion edge.
- Back-to-back: a new request is acceptable at the first edge after busy falls (busy=0 sampled).
- Results, all computed from the latched operands:
  - MULT: signed 64-bit product; hi = [63:32], lo = [31:0].
  - MULTU: unsigned 64-bit product, same split.
  - DIV: signed. Quotient truncates toward zero; remainder takes the sign of the dividend. lo = quotient, hi = remainder.
  - DIVU: unsigned; lo = quotient, hi = remainder.
  - DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (B=0, DIV or DIVU): the operation runs the full DIV_LAT with busy, then hi/lo are left unchanged.
- Outputs hi/lo/busy are registers only, with no combinational path from inputs.

Decomposition:
- Shared package/header holds:
  - the md_op encodings (MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO)
  - the default latencies, so the controller's stall logic and decoder share the same values.
- One natural sub-module: md_result_calc, a combinational block mapping (op, A, B) to {hi_res, lo_res, valid}. Its valid output goes low on divide-by-zero.
- The top holds the counter, busy FSM (IDLE/RUN) and HI/LO registers.

Test Plan:
- Reset, then MTHI A=0x12345678, then MTLO A=0x9ABCDEF0 on consecutive cycles -> hi=0x12345678 and lo=0x9ABCDEF0, each 1 cycle after its request; busy never asserts.
- MULT A=0xFFFFFFFE (-2), B=0x00000003 -> busy high exactly 5 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFA at the busy-falling edge. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU A=7, B=2 -> lo=3, hi=1. DIV 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Issue MULT, then drive MTLO and DIV during busy -> both ignored; only the MULT result lands. The next request is accepted on the first cycle after busy=0.
- DIVU B=0 with hi=0x11, lo=0x22 preset -> busy 10 cycles, hi/lo stay 0x11/0x22.
- Start DIV, assert reset at cycle 4 of busy -> next edge busy=0, hi=lo=0, and no later write occurs.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared encodings and default latencies for the multiply/divide unit.
// Decoder, stall logic and the MDU all import this so they agree on md_op values.
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    localparam int DEFAULT_MULT_LAT = 5;
    localparam int DEFAULT_DIV_LAT  = 10;
    localparam int CNT_W            = 5;

    function automatic logic is_long_op(input md_op_e op);
        return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
    endfunction

endpackage

// File: rtl/mult_div_unit_result_calc.sv
// Combinational result generator: maps (op, a, b) to the HI/LO pair.
// valid drops on divide-by-zero so the caller leaves HI/LO untouched.
module md_result_calc
    import mult_div_unit_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        valid
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               sovf;
    logic        [31:0] sdiv_b;
    logic        [31:0] udiv_b;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quot_u;
    logic        [31:0] rem_u;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Dividing by 1 instead of -1 for MIN/-1 yields exactly the required
    // quotient 0x80000000 with zero remainder, and keeps the divider overflow-free.
    assign sovf   = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign sdiv_b = ((b == 32'd0) || sovf) ? 32'd1 : b;
    assign udiv_b = (b == 32'd0) ? 32'd1 : b;

    assign quot_s = $signed(a) / $signed(sdiv_b);
    assign rem_s  = $signed(a) % $signed(sdiv_b);
    assign quot_u = a / udiv_b;
    assign rem_u  = a % udiv_b;

    always_comb begin
        hi_res = 32'd0;
        lo_res = 32'd0;
        valid  = 1'b0;
        case (op)
            MD_MULT: begin
                {hi_res, lo_res} = prod_s;
                valid            = 1'b1;
            end
            MD_MULTU: begin
                {hi_res, lo_res} = prod_u;
                valid            = 1'b1;
            end
            MD_DIV: begin
                lo_res = quot_s;
                hi_res = rem_s;
                valid  = (b != 32'd0);
            end
            MD_DIVU: begin
                lo_res = quot_u;
                hi_res = rem_u;
                valid  = (b != 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS multiply/divide unit holding HI/LO.
// busy covers the whole latency window so control can stall MFHI/MFLO and new MDU ops.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_LAT = DEFAULT_MULT_LAT,
    parameter int DIV_LAT  = DEFAULT_DIV_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e             state;
    state_e             state_next;
    md_op_e             op_in;
    md_op_e             op_q;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic [CNT_W-1:0]   count;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;
    logic [31:0]        hi_res;
    logic [31:0]        lo_res;
    logic               res_valid;
    logic               start;
    logic               done;

    assign op_in = md_op_e'(md_op);
    assign start = (state == IDLE) && is_long_op(op_in);
    assign done  = (state == RUN) && (count == CNT_W'(1));

    md_result_calc u_calc (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .hi_res (hi_res),
        .lo_res (lo_res),
        .valid  (res_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (done)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Requests are only decoded while idle; anything arriving mid-operation is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            op_q  <= MD_NONE;
            a_q   <= '0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else if (state == IDLE) begin
            case (op_in)
                MD_MTHI: hi_q <= A;
                MD_MTLO: lo_q <= A;
                MD_MULT, MD_MULTU: begin
                    op_q  <= op_in;
                    a_q   <= A;
                    b_q   <= B;
                    count <= CNT_W'(MULT_LAT);
                end
                MD_DIV, MD_DIVU: begin
                    op_q  <= op_in;
                    a_q   <= A;
                    b_q   <= B;
                    count <= CNT_W'(DIV_LAT);
                end
                default: ;
            endcase
        end else begin
            count <= count - 1'b1;
            if (done && res_valid) begin
                hi_q <= hi_res;
                lo_q <= lo_res;
            end
        end
    end

    assign busy = (state == RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO/latency are queued at issue
// and compared when busy falls.
module tb_mult_div_unit;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  mdOp;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        busyOut;
    logic [31:0] hiOut;
    logic [31:0] loOut;

    exp_t        sb[$];
    logic [31:0] shHi;
    logic [31:0] shLo;
    int          checks   = 0;
    int          failures = 0;

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .md_op (mdOp),
        .A     (opA),
        .B     (opB),
        .busy  (busyOut),
        .hi    (hiOut),
        .lo    (loOut)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        r;
        logic [63:0] pu;
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] rm;
        r.hi  = shHi;
        r.lo  = shLo;
        r.lat = (op == OP_MULT || op == OP_MULTU) ? 5 : 10;
        pu    = {32'd0, a} * {32'd0, b};
        if (op == OP_MULTU) begin
            {r.hi, r.lo} = pu;
        end else if (op == OP_MULT) begin
            if (a[31]) pu = pu - {b, 32'd0};
            if (b[31]) pu = pu - {a, 32'd0};
            {r.hi, r.lo} = pu;
        end else if (b != 32'd0) begin
            if (op == OP_DIVU) begin
                r.lo = a / b;
                r.hi = a % b;
            end else begin
                ma = a[31] ? -a : a;
                mb = b[31] ? -b : b;
                q  = ma / mb;
                rm = ma % mb;
                r.lo = (a[31] ^ b[31]) ? -q : q;
                r.hi = a[31] ? -rm : rm;
            end
        end
        return r;
    endfunction

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        mdOp = op;
        opA  = a;
        opB  = b;
        step();
        mdOp = OP_NONE;
    endtask

    task automatic issueLong(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        sb.push_back(model(op, a, b));
        applyStimulus(op, a, b);
    endtask

    // Counts busy samples from the current one, then pops and checks the completion.
    task automatic checkOutput(input int startCnt, input string name);
        int   cnt     = startCnt;
        bit   heldBad = 1'b0;
        exp_t e;
        while (busyOut === 1'b1 && cnt < 200) begin
            if (hiOut !== shHi || loOut !== shLo) heldBad = 1'b1;
            cnt++;
            step();
        end
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("[TB] FAIL %s_scoreboard: got empty queue, required an entry", name);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (cnt !== e.lat) begin
            failures++;
            $display("[TB] FAIL %s_busy_len: got %0d required %0d", name, cnt, e.lat);
        end
        checks++;
        if (heldBad !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s_held: got hi/lo change during busy, required 0 changes", name);
        end
        checks++;
        if (hiOut !== e.hi) begin
            failures++;
            $display("[TB] FAIL %s_hi: got %h required %h", name, hiOut, e.hi);
        end
        checks++;
        if (loOut !== e.lo) begin
            failures++;
            $display("[TB] FAIL %s_lo: got %h required %h", name, loOut, e.lo);
        end
        shHi = e.hi;
        shLo = e.lo;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mdOp  = OP_NONE;
        opA   = '0;
        opB   = '0;
        step();
        step();
        reset = 1'b0;
        checks++;
        if (busyOut !== 1'b0 || hiOut !== 32'd0 || loOut !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_state: got busy=%b hi=%h lo=%h required 0/0/0", busyOut, hiOut, loOut);
        end
        shHi = 32'd0;
        shLo = 32'd0;
    endtask

    task automatic test_move();
        applyStimulus(OP_MTHI, 32'h1234_5678, 32'd0);
        checks++;
        if (hiOut !== 32'h1234_5678 || loOut !== 32'd0 || busyOut !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mthi: got hi=%h lo=%h busy=%b required 12345678/0/0", hiOut, loOut, busyOut);
        end
        applyStimulus(OP_MTLO, 32'h9ABC_DEF0, 32'd0);
        checks++;
        if (hiOut !== 32'h1234_5678 || loOut !== 32'h9ABC_DEF0 || busyOut !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mtlo: got hi=%h lo=%h busy=%b required 12345678/9abcdef0/0", hiOut, loOut, busyOut);
        end
        shHi = 32'h1234_5678;
        shLo = 32'h9ABC_DEF0;
    endtask

    task automatic test_arith();
        issueLong(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        checkOutput(0, "mult");
        issueLong(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
        checkOutput(0, "multu");
        issueLong(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        checkOutput(0, "div_neg");
        issueLong(OP_DIVU, 32'd7, 32'd2);
        checkOutput(0, "divu");
        issueLong(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput(0, "div_ovf");
        // Fixed test-plan values, independent of the model.
        checks++;
        if (hiOut !== 32'd0 || loOut !== 32'h8000_0000) begin
            failures++;
            $display("[TB] FAIL div_ovf_const: got hi=%h lo=%h required 0/80000000", hiOut, loOut);
        end
    endtask

    task automatic test_back_to_back();
        issueLong(OP_MULT, 32'd3, 32'd5);
        applyStimulus(OP_MTLO, 32'hDEAD_BEEF, 32'd0);
        applyStimulus(OP_DIV, 32'd100, 32'd7);
        checkOutput(2, "mult_ignore");
        applyStimulus(OP_MTHI, 32'hCAFE_0001, 32'd0);
        checks++;
        if (hiOut !== 32'hCAFE_0001 || loOut !== 32'd15 || busyOut !== 1'b0) begin
            failures++;
            $display("[TB] FAIL after_busy_accept: got hi=%h lo=%h busy=%b required cafe0001/0000000f/0", hiOut, loOut, busyOut);
        end
        shHi = 32'hCAFE_0001;
    endtask

    task automatic test_div_zero();
        applyStimulus(OP_MTHI, 32'h11, 32'd0);
        applyStimulus(OP_MTLO, 32'h22, 32'd0);
        shHi = 32'h11;
        shLo = 32'h22;
        issueLong(OP_DIVU, 32'd5, 32'd0);
        checkOutput(0, "divu_zero");
        issueLong(OP_DIV, 32'hFFFF_0000, 32'd0);
        checkOutput(0, "div_zero");
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 8; i++) begin
            op = 3'(1 + $urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            if (op == OP_DIV || op == OP_DIVU) b = b >> $urandom_range(0, 31);
            issueLong(op, a, b);
            checkOutput(0, "random");
        end
    endtask

    task automatic test_reset_mid_op();
        bit lateWrite = 1'b0;
        applyStimulus(OP_DIV, 32'd100, 32'd7);
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (busyOut !== 1'b0 || hiOut !== 32'd0 || loOut !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_mid_op: got busy=%b hi=%h lo=%h required 0/0/0", busyOut, hiOut, loOut);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            if (busyOut !== 1'b0 || hiOut !== 32'd0 || loOut !== 32'd0) lateWrite = 1'b1;
        end
        checks++;
        if (lateWrite !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_no_late_write: got late activity, required none");
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_move();
        test_arith();
        test_back_to_back();
        test_div_zero();
        test_random();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
